// File: rtl/conv_pkg.sv
// Shared constants and FSM encoding for the CONV engine pooling stage.
//   DATA_WIDTH : signed sample width of L0/L1 data
//   IMG_DIM    : side of the layer-0 feature map
//   POOL_DIM   : side of the pooled layer-1 map
package conv_pkg;

  localparam int unsigned DATA_WIDTH = 20;
  localparam int unsigned IMG_DIM    = 64;
  localparam int unsigned POOL_DIM   = IMG_DIM / 2;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_LAST  = 3'd2;
  localparam logic [2:0] ST_WRITE = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE  = ST_IDLE,
    S_FETCH = ST_FETCH,
    S_LAST  = ST_LAST,
    S_WRITE = ST_WRITE,
    S_DONE  = ST_DONE
  } state_t;

endpackage

// File: rtl/four_num_sorter.sv
// Signed max-of-four comparator used to reduce one 2x2 pooling window.
//   i_a..i_d : window samples (signed)
//   o_max    : largest sample; ties return the shared value
module four_num_sorter #(
  parameter int unsigned DATA_WIDTH = 20
) (
  input  logic signed [DATA_WIDTH-1:0] i_a,
  input  logic signed [DATA_WIDTH-1:0] i_b,
  input  logic signed [DATA_WIDTH-1:0] i_c,
  input  logic signed [DATA_WIDTH-1:0] i_d,
  output logic signed [DATA_WIDTH-1:0] o_max
);

  logic signed [DATA_WIDTH-1:0] w_ab;
  logic signed [DATA_WIDTH-1:0] w_cd;

  // Two-level tournament keeps the compare depth at two.
  assign w_ab  = (i_a >= i_b) ? i_a : i_b;
  assign w_cd  = (i_c >= i_d) ? i_c : i_d;
  assign o_max = (w_ab >= w_cd) ? w_ab : w_cd;

endmodule

// File: rtl/maxpool_ctrl.sv
// 2x2 / stride-2 max-pooling sequencer: reads each window of the L0 map,
// reduces it with four_num_sorter and writes the result to L1 in raster order.
//   clk, rst_n      : clock, asynchronous active-low reset
//   start           : begin pooling (accepted in IDLE only)
//   busy, done      : run in progress / one-cycle completion pulse
//   l0_rd, l0_addr  : L0 read strobe and {row,col} address
//   l0_rdata        : L0 data, valid one cycle after l0_rd
//   l1_wr, l1_addr  : L1 write strobe and {oy,ox} address
//   l1_wdata        : pooled window maximum
module maxpool_ctrl #(
  parameter int unsigned DATA_WIDTH  = conv_pkg::DATA_WIDTH,
  parameter int unsigned IN_DIM_LOG2 = $clog2(conv_pkg::IMG_DIM)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  output logic                          busy,
  output logic                          done,
  output logic                          l0_rd,
  output logic [2*IN_DIM_LOG2-1:0]      l0_addr,
  input  logic signed [DATA_WIDTH-1:0]  l0_rdata,
  output logic                          l1_wr,
  output logic [2*IN_DIM_LOG2-3:0]      l1_addr,
  output logic signed [DATA_WIDTH-1:0]  l1_wdata
);

  import conv_pkg::state_t;
  import conv_pkg::S_IDLE;
  import conv_pkg::S_FETCH;
  import conv_pkg::S_LAST;
  import conv_pkg::S_WRITE;
  import conv_pkg::S_DONE;

  localparam int unsigned CW    = IN_DIM_LOG2 - 1;
  localparam int unsigned L0_AW = 2 * IN_DIM_LOG2;
  localparam int unsigned L1_AW = 2 * CW;

  state_t                       r_state, w_nxt_state;
  logic [1:0]                   r_k, w_nxt_k;
  logic [CW-1:0]                r_ox, r_oy, w_nxt_ox, w_nxt_oy;
  logic signed [DATA_WIDTH-1:0] r_a, r_b, r_c, r_d;
  logic signed [DATA_WIDTH-1:0] w_d, w_max;

  logic                         r_busy, r_done, r_l0_rd, r_l1_wr;
  logic [L0_AW-1:0]             r_l0_addr;
  logic [L1_AW-1:0]             r_l1_addr;
  logic signed [DATA_WIDTH-1:0] r_l1_wdata;

  logic                         w_nxt_busy, w_nxt_done, w_nxt_l0_rd, w_nxt_l1_wr;
  logic [L0_AW-1:0]             w_nxt_l0_addr;
  logic [L1_AW-1:0]             w_nxt_l1_addr;
  logic signed [DATA_WIDTH-1:0] w_nxt_l1_wdata;

  // The fourth sample arrives during LAST; bypass it so the registered
  // l1_wdata is ready in the WRITE cycle itself.
  assign w_d = (r_state == S_LAST) ? l0_rdata : r_d;

  four_num_sorter #(.DATA_WIDTH(DATA_WIDTH)) u_sorter (
    .i_a   (r_a),
    .i_b   (r_b),
    .i_c   (r_c),
    .i_d   (w_d),
    .o_max (w_max)
  );

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_k        <= 2'd0;
      r_ox       <= '0;
      r_oy       <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_l0_rd    <= 1'b0;
      r_l0_addr  <= '0;
      r_l1_wr    <= 1'b0;
      r_l1_addr  <= '0;
      r_l1_wdata <= '0;
    end else begin
      r_state    <= w_nxt_state;
      r_k        <= w_nxt_k;
      r_ox       <= w_nxt_ox;
      r_oy       <= w_nxt_oy;
      r_busy     <= w_nxt_busy;
      r_done     <= w_nxt_done;
      r_l0_rd    <= w_nxt_l0_rd;
      r_l0_addr  <= w_nxt_l0_addr;
      r_l1_wr    <= w_nxt_l1_wr;
      r_l1_addr  <= w_nxt_l1_addr;
      r_l1_wdata <= w_nxt_l1_wdata;
    end
  end

  // Next state, counters, and the output values for the next cycle.
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_k     = r_k;
    w_nxt_ox    = r_ox;
    w_nxt_oy    = r_oy;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_nxt_state = S_FETCH;
          w_nxt_k     = 2'd0;
          w_nxt_ox    = '0;
          w_nxt_oy    = '0;
        end
      end
      S_FETCH: begin
        w_nxt_k = r_k + 2'd1;
        if (r_k == 2'd3) w_nxt_state = S_LAST;
      end
      S_LAST: w_nxt_state = S_WRITE;
      S_WRITE: begin
        if (&{r_oy, r_ox}) begin
          w_nxt_state = S_DONE;
        end else begin
          // ox carries into oy when it wraps.
          {w_nxt_oy, w_nxt_ox} = L1_AW'({r_oy, r_ox} + L1_AW'(1));
          w_nxt_k     = 2'd0;
          w_nxt_state = S_FETCH;
        end
      end
      S_DONE: begin
        w_nxt_state = S_IDLE;
        w_nxt_ox    = '0;
        w_nxt_oy    = '0;
      end
      default: w_nxt_state = S_IDLE;
    endcase

    w_nxt_busy  = (w_nxt_state == S_FETCH) || (w_nxt_state == S_LAST) ||
                  (w_nxt_state == S_WRITE);
    w_nxt_done  = (w_nxt_state == S_DONE);
    w_nxt_l0_rd = (w_nxt_state == S_FETCH);
    w_nxt_l1_wr = (w_nxt_state == S_WRITE);

    // Addresses/data only move with their strobe to avoid needless toggling.
    w_nxt_l0_addr  = r_l0_addr;
    w_nxt_l1_addr  = r_l1_addr;
    w_nxt_l1_wdata = r_l1_wdata;
    if (w_nxt_l0_rd) w_nxt_l0_addr = {w_nxt_oy, w_nxt_k[1], w_nxt_ox, w_nxt_k[0]};
    if (w_nxt_l1_wr) begin
      w_nxt_l1_addr  = {w_nxt_oy, w_nxt_ox};
      w_nxt_l1_wdata = w_max;
    end
  end

  // Sample registers: data issued at k lands one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a <= '0;
      r_b <= '0;
      r_c <= '0;
      r_d <= '0;
    end else begin
      if (r_state == S_FETCH) begin
        case (r_k)
          2'd1:    r_a <= l0_rdata;
          2'd2:    r_b <= l0_rdata;
          2'd3:    r_c <= l0_rdata;
          default: ;
        endcase
      end
      if (r_state == S_LAST) r_d <= l0_rdata;
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign l0_rd    = r_l0_rd;
  assign l0_addr  = r_l0_addr;
  assign l1_wr    = r_l1_wr;
  assign l1_addr  = r_l1_addr;
  assign l1_wdata = r_l1_wdata;

endmodule
